// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  mem_bus_arbiter_pkg
//  Shared state encoding, stall levels and sizing helper for the arbiter.
//  Rev 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_BUS   = 3'd1,
        ARB_MEM_BUS  = 3'd2,
        ARB_IF_DONE  = 3'd3,
        ARB_MEM_DONE = 3'd4
    } arb_state_e;

    localparam logic C_RST_ENABLE = 1'b1;
    localparam logic C_STOP       = 1'b1;
    localparam logic C_NO_STOP    = 1'b0;

    // Counter must reach TIMEOUT-1; never narrower than one bit.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  mem_bus_arbiter_if
//  Wishbone-style single-port memory bus (combined cyc/stb).
//  Rev 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cyc_stb;
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output cyc_stb, we, sel, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  cyc_stb, we, sel, addr, wdata,
        output rdata, ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
//  mem_bus_arbiter_watchdog
//  Counts cycles of an open bus transaction; flags expiry at TIMEOUT-1.
//  Rev 1.0
// ============================================================================
module mem_bus_arbiter_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      expire_o
);

    localparam int CNT_W = wd_cnt_width(TIMEOUT);

    if (TIMEOUT > 0) begin : g_wd_on
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst == C_RST_ENABLE || clr_i || !en_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_wd_off
        logic w_unused;
        assign w_unused = ^{clk, rst, en_i, clr_i};
        assign expire_o = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_bus_arbiter
//  Shares one memory bus between fetch (IF) and data (MEM); MEM has priority.
//  Rev 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [5:0]        stall,
    input  wire logic              flush,
    input  wire logic              if_ce,
    input  wire logic [ADDR_W-1:0] if_addr,
    output logic      [DATA_W-1:0] if_rdata,
    input  wire logic              mem_ce,
    input  wire logic              mem_we,
    input  wire logic [3:0]        mem_sel,
    input  wire logic [ADDR_W-1:0] mem_addr,
    input  wire logic [DATA_W-1:0] mem_wdata,
    output logic      [DATA_W-1:0] mem_rdata,
    output logic                   stallreq_from_if,
    output logic                   stallreq_from_mem,
    mem_bus_arbiter_if.master      bus,
    output logic                   bus_timeout
);

    arb_state_e        state_q;
    logic              cyc_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              timeout_q;
    logic              flushed_q;

    logic              w_in_bus;
    logic              w_expire;
    logic              w_done;
    logic [DATA_W-1:0] w_result;
    logic              w_stall_unused;

    assign w_stall_unused = ^{stall[5], stall[3:2], stall[0]};

    assign w_in_bus = (state_q == ARB_IF_BUS) || (state_q == ARB_MEM_BUS);
    assign w_done   = bus.ack || w_expire;
    // An ack arriving in the abort cycle still counts as a normal completion.
    assign w_result = (bus.ack && !we_q) ? bus.rdata : '0;

    mem_bus_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .en_i     (w_in_bus),
        .clr_i    (w_in_bus && bus.ack),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst == C_RST_ENABLE) begin
            state_q     <= ARB_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            timeout_q   <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    flushed_q <= 1'b0;
                    if (mem_ce) begin
                        state_q <= ARB_MEM_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= mem_we;
                        sel_q   <= mem_sel;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                    end else if (if_ce && !flush) begin
                        state_q <= ARB_IF_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                    end
                end
                ARB_IF_BUS: begin
                    // A flush never cuts the bus cycle short; it only voids the result.
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (w_done) begin
                        cyc_q     <= 1'b0;
                        timeout_q <= !bus.ack;
                        if (flush || flushed_q) begin
                            state_q <= ARB_IDLE;
                        end else begin
                            if_rdata_q <= w_result;
                            state_q    <= ARB_IF_DONE;
                        end
                    end
                end
                ARB_MEM_BUS: begin
                    if (w_done) begin
                        cyc_q       <= 1'b0;
                        timeout_q   <= !bus.ack;
                        mem_rdata_q <= w_result;
                        state_q     <= ARB_MEM_DONE;
                    end
                end
                ARB_IF_DONE: begin
                    if (flush || !stall[1]) begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_MEM_DONE: begin
                    if (!stall[4]) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.cyc_stb = cyc_q;
    assign bus.we      = we_q;
    assign bus.sel     = sel_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus_timeout = timeout_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;

    assign stallreq_from_if  = (if_ce  && (state_q != ARB_IF_DONE))  ? C_STOP : C_NO_STOP;
    assign stallreq_from_mem = (mem_ce && (state_q != ARB_MEM_DONE)) ? C_STOP : C_NO_STOP;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mem_bus_arbiter
//  Randomized transaction-level bench with a latency/ordering reference model.
//  Rev 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          len;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    stall = '0;
    logic          flush = 1'b0;
    logic          if_ce = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          mem_ce = 1'b0;
    logic          mem_we = 1'b0;
    logic [3:0]    mem_sel = '0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          stallreq_from_if;
    logic          stallreq_from_mem;
    logic          bus_timeout;

    int n_checks = 0;
    int n_errors = 0;

    txn_t        log_q[$];
    int          wait_q[$];
    txn_t        cur;
    logic        prev_cyc = 1'b0;
    int          slv_wait = 0;
    int          slv_cnt = 0;
    int          to_cnt = 0;
    int          stab_err = 0;
    logic [31:0] last_if = '0;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .if_ce             (if_ce),
        .if_addr           (if_addr),
        .if_rdata          (if_rdata),
        .mem_ce            (mem_ce),
        .mem_we            (mem_we),
        .mem_sel           (mem_sel),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem),
        .bus               (bus),
        .bus_timeout       (bus_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h2401_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave with per-transaction wait states; also logs every bus cycle it sees.
    always @(negedge clk) begin
        if (bus.cyc_stb) begin
            if (!prev_cyc) begin
                cur.addr  = bus.addr;
                cur.we    = bus.we;
                cur.sel   = bus.sel;
                cur.wdata = bus.wdata;
                cur.len   = 1;
                slv_wait  = 0;
                if (wait_q.size() > 0) slv_wait = wait_q.pop_front();
                slv_cnt = 0;
            end else begin
                cur.len++;
                if ({bus.we, bus.sel, bus.addr, bus.wdata} != {cur.we, cur.sel, cur.addr, cur.wdata})
                    stab_err++;
            end
            bus.ack   = (slv_cnt == slv_wait);
            bus.rdata = mem_model(bus.addr);
            slv_cnt++;
        end else begin
            if (prev_cyc) log_q.push_back(cur);
            bus.ack   = 1'b0;
            bus.rdata = $urandom();
        end
        prev_cyc = bus.cyc_stb;
        if (bus_timeout) to_cnt++;
    end

    task automatic run_op(input bit do_if, input bit do_mem,
                          input logic [31:0] ia, input logic [31:0] ma,
                          input bit we, input logic [3:0] sel, input logic [31:0] wd,
                          input int wi, input int wm, input int hi, input int hm);
        logic [31:0] exp_if, exp_mem;
        bit          if_pend, mem_pend;
        int          if_lat, to0, exp_to;
        txn_t        exp_q[$];
        txn_t        t;
        exp_if  = (wi >= TO) ? 32'h0 : mem_model(ia);
        exp_mem = (wm >= TO || we) ? 32'h0 : mem_model(ma);
        exp_to  = ((do_mem && wm >= TO) ? 1 : 0) + ((do_if && wi >= TO) ? 1 : 0);
        log_q.delete();
        wait_q.delete();
        to0 = to_cnt;
        stab_err = 0;
        if (do_mem) begin
            t.addr = ma; t.we = we; t.sel = sel; t.wdata = wd;
            t.len = (wm >= TO) ? TO : wm + 1;
            exp_q.push_back(t);
            wait_q.push_back(wm);
        end
        if (do_if) begin
            t.addr = ia; t.we = 1'b0; t.sel = 4'hF; t.wdata = '0;
            t.len = (wi >= TO) ? TO : wi + 1;
            exp_q.push_back(t);
            wait_q.push_back(wi);
        end
        if_ce = do_if; if_addr = ia;
        mem_ce = do_mem; mem_we = we; mem_sel = sel; mem_addr = ma; mem_wdata = wd;
        stall = '0; stall[1] = do_if; stall[4] = do_mem;
        if_pend = do_if; mem_pend = do_mem; if_lat = -1;
        for (int c = 1; c <= 300 && (if_pend || mem_pend); c++) begin
            @(negedge clk);
            if (mem_pend && !stallreq_from_mem) begin
                chk("mem_rdata", mem_rdata, exp_mem);
                if (hm > 0) begin stall[4] = 1'b1; hm--; end
                else begin stall[4] = 1'b0; mem_ce = 1'b0; mem_pend = 1'b0; end
            end
            if (if_pend && !stallreq_from_if) begin
                if (if_lat < 0) if_lat = c;
                chk("if_rdata", if_rdata, exp_if);
                if (hi > 0) begin stall[1] = 1'b1; hi--; end
                else begin stall[1] = 1'b0; if_ce = 1'b0; if_pend = 1'b0; end
            end
        end
        chk("op_done", {30'd0, if_pend, mem_pend}, 32'd0);
        if_ce = 1'b0; mem_ce = 1'b0; stall = '0;
        @(negedge clk);
        chk("n_txn", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("txn_addr", log_q[i].addr, exp_q[i].addr);
            chk("txn_we", {31'd0, log_q[i].we}, {31'd0, exp_q[i].we});
            chk("txn_len", log_q[i].len, exp_q[i].len);
            if (do_mem && i == 0) begin
                chk("txn_sel", {28'd0, log_q[i].sel}, {28'd0, exp_q[i].sel});
                chk("txn_wdata", log_q[i].wdata, exp_q[i].wdata);
            end
        end
        chk("timeouts", to_cnt - to0, exp_to);
        chk("bus_stable", stab_err, 0);
        chk("cyc_idle", {31'd0, bus.cyc_stb}, 32'd0);
        if (do_if && !do_mem) chk("if_latency", if_lat, (wi >= TO) ? TO + 1 : wi + 2);
        if (do_if) last_if = exp_if;
    endtask

    task automatic run_flush(input logic [31:0] ia, input int wi);
        log_q.delete();
        wait_q.delete();
        wait_q.push_back(wi);
        if_ce = 1'b1; if_addr = ia; stall = 6'b000010;
        @(negedge clk);
        flush = 1'b1; if_ce = 1'b0; stall = '0;
        @(negedge clk);
        flush = 1'b0;
        repeat (wi + 3) @(negedge clk);
        chk("fl_n_txn", log_q.size(), 1);
        if (log_q.size() > 0) chk("fl_len", log_q[0].len, wi + 1);
        chk("fl_if_rdata", if_rdata, last_if);
        chk("fl_cyc", {31'd0, bus.cyc_stb}, 32'd0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_cyc"}, {31'd0, bus.cyc_stb}, 32'd0);
        chk({pfx, "_we"}, {31'd0, bus.we}, 32'd0);
        chk({pfx, "_sel"}, {28'd0, bus.sel}, 32'd0);
        chk({pfx, "_addr"}, bus.addr, 32'd0);
        chk({pfx, "_wdata"}, bus.wdata, 32'd0);
        chk({pfx, "_if_rdata"}, if_rdata, 32'd0);
        chk({pfx, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({pfx, "_timeout"}, {31'd0, bus_timeout}, 32'd0);
    endtask

    initial begin
        int waits[7];
        waits = '{0, 1, 2, 3, 7, 8, 12};
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_sreq", {30'd0, stallreq_from_if, stallreq_from_mem}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed: plain fetch, dual request, held delivery, timeout, boundaries.
        run_op(1, 0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 0, 0, 0, 0);
        run_op(1, 1, 32'h100, 32'h200, 0, 4'hF, 32'h0, 0, 0, 1, 2);
        run_op(1, 0, 32'h104, 32'h0, 0, 4'h0, 32'h0, 0, 0, 4, 0);
        run_op(0, 1, 32'h0, 32'h208, 0, 4'hF, 32'h0, 0, 20, 0, 0);
        run_op(1, 0, 32'h108, 32'h0, 0, 4'h0, 32'h0, TO - 1, 0, 0, 0);
        run_op(1, 0, 32'h10C, 32'h0, 0, 4'h0, 32'h0, TO, 0, 0, 0);
        run_op(0, 1, 32'h0, 32'h20C, 1, 4'b0101, 32'h1234_5678, 0, 1, 0, 1);
        run_flush(32'h110, 0);
        run_flush(32'h114, 2);

        // Reset in the middle of a MEM write.
        log_q.delete(); wait_q.delete(); wait_q.push_back(50);
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
        mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D; stall = 6'b010000;
        repeat (3) @(negedge clk);
        chk("rst_pre_cyc", {31'd0, bus.cyc_stb}, 32'd1);
        chk("rst_pre_sel", {28'd0, bus.sel}, 32'h3);
        rst = 1'b1; mem_ce = 1'b0; mem_we = 1'b0; stall = '0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        last_if = '0;
        @(negedge clk);
        run_op(1, 0, 32'h118, 32'h0, 0, 4'h0, 32'h0, 1, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] ia, ma, wd;
            kind = $urandom_range(0, 3);
            ia = $urandom() & 32'hFFFF_FFFC;
            ma = $urandom() & 32'hFFFF_FFFC;
            wd = $urandom();
            case (kind)
                0: run_op(1, 0, ia, ma, 0, 4'hF, 32'h0, waits[$urandom_range(0, 6)], 0,
                          $urandom_range(0, 3), 0);
                1: run_op(0, 1, ia, ma, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), wd,
                          0, waits[$urandom_range(0, 6)], 0, $urandom_range(0, 3));
                2: run_op(1, 1, ia, ma, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), wd,
                          waits[$urandom_range(0, 6)], waits[$urandom_range(0, 6)],
                          $urandom_range(0, 3), $urandom_range(0, 3));
                default: run_flush(ia, $urandom_range(0, 3));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no end of run, expected finish before 1ms");
        $fatal(1);
    end

endmodule
`default_nettype wire
